// File: rtl/keypad_row_scanner_pkg.sv
// Shared types and helpers for the 8x4 keypad row scanner.
// Key codes are {row[2:0], col_idx[1:0]}.
package keypad_pkg;

   localparam int ROWS   = 8;
   localparam int COLS   = 4;
   localparam int CODE_W = 5;

   typedef enum logic {
      RELEASED = 1'b0,
      HELD     = 1'b1
   } key_state_t;

   // The lowest column wins when several columns of one row are active.
   function automatic logic [1:0] lowest_set(input logic [COLS-1:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = COLS - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = 2'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_row_scanner_scan_timer.sv
// Dwell and row counters for the keypad scanner.
// Strobes mark the column-sample cycle and the final sample of a full scan.
module keypad_scan_timer
   import keypad_pkg::*;
#(
   parameter int DWELL_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_en,
   output logic [2:0] row_sel,
   output logic       sample_stb,
   output logic       scan_end_stb
);

   localparam int            DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [2:0]    ROW_LAST   = 3'(ROWS - 1);

   logic [DW-1:0] dwell_cnt;

   assign sample_stb   = scan_en && (dwell_cnt == DWELL_LAST);
   assign scan_end_stb = sample_stb && (row_sel == ROW_LAST);

   // Everything freezes while scan_en is low, so a paused scan resumes mid-dwell.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_cnt <= '0;
         row_sel   <= 3'd0;
      end else if (sample_stb) begin
         dwell_cnt <= '0;
         row_sel   <= (row_sel == ROW_LAST) ? 3'd0 : row_sel + 3'd1;
      end else if (scan_en) begin
         dwell_cnt <= dwell_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/keypad_row_scanner.sv
// Scans an 8x4 key matrix, debounces whole-scan results and reports
// one key code per press over a valid/ready handshake.
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int DWELL_CYCLES   = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scan_en,
   input  logic [COLS-1:0]   col,
   output logic [2:0]        row_sel,
   output logic [CODE_W-1:0] key_code,
   output logic              key_valid,
   input  logic              key_ready,
   output logic              overrun
);

   localparam int            SW         = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

   logic              sample_stb;
   logic              scan_end_stb;

   logic              cand_hit;
   logic [CODE_W-1:0] cand_code;
   logic              scan_hit;
   logic [CODE_W-1:0] scan_code;

   logic              prev_hit;
   logic [CODE_W-1:0] prev_code;
   logic [SW-1:0]     stable_cnt;
   logic [SW-1:0]     stable_next;
   logic              is_stable;

   key_state_t        state;
   key_state_t        state_next;
   logic [CODE_W-1:0] held_code;
   logic [CODE_W-1:0] held_code_next;
   logic              report;

   keypad_scan_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .scan_en     (scan_en),
      .row_sel     (row_sel),
      .sample_stb  (sample_stb),
      .scan_end_stb(scan_end_stb)
   );

   // Row 0 begins a new scan, so any hit left over from the previous scan is ignored.
   always_comb begin
      scan_hit  = cand_hit && (row_sel != 3'd0);
      scan_code = scan_hit ? cand_code : '0;
      if (!scan_hit && (col != '0)) begin
         scan_hit  = 1'b1;
         scan_code = {row_sel, lowest_set(col)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_hit  <= 1'b0;
         cand_code <= '0;
      end else if (sample_stb) begin
         cand_hit  <= scan_hit;
         cand_code <= scan_code;
      end
   end

   // A no-hit scan always carries code 0, so hit and code compare as one value.
   always_comb begin
      stable_next = SW'(1);
      if ((scan_hit == prev_hit) && (scan_code == prev_code)) begin
         stable_next = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
      end
      is_stable = (stable_next == STABLE_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_hit   <= 1'b0;
         prev_code  <= '0;
         stable_cnt <= '0;
      end else if (scan_end_stb) begin
         prev_hit   <= scan_hit;
         prev_code  <= scan_code;
         stable_cnt <= stable_next;
      end
   end

   always_comb begin
      state_next     = state;
      held_code_next = held_code;
      report         = 1'b0;
      if (scan_end_stb && is_stable) begin
         case (state)
            RELEASED: begin
               if (scan_hit) begin
                  report         = 1'b1;
                  state_next     = HELD;
                  held_code_next = scan_code;
               end
            end
            HELD: begin
               if (!scan_hit) begin
                  state_next = RELEASED;
               end else if (scan_code != held_code) begin
                  report         = 1'b1;
                  held_code_next = scan_code;
               end
            end
            default: state_next = RELEASED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RELEASED;
         held_code <= '0;
      end else begin
         state     <= state_next;
         held_code <= held_code_next;
      end
   end

   // An accept in the same cycle frees the slot, so the new code can load without overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (report) begin
            if (!key_valid || key_ready) begin
               key_code  <= scan_code;
               key_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
         end
      end
   end

endmodule
